// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// master drives operands and consumes results; slave is the pipeline.
interface addsub_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: one SEG-bit segment resolved per stage, carry
// registered between stages, single global advance for back-pressure.
module addsub_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEG   = 4
) (
  input logic          clk,
  input logic          rst_n,
  addsub_pipe_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / SEG;

  if (WIDTH < 2 || SEG == 0 || SEG > WIDTH || (WIDTH % SEG) != 0) begin : g_param_check
    $error("addsub_pipe: WIDTH must be >= 2 and an integer multiple of SEG");
  end

  logic out_vld;
  logic adv;

  // Whole pipe moves when the output slot is empty or being taken
  assign adv          = ~out_vld | bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_s;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             src_c;
    logic             src_v;
    logic             vld_q;
    logic [SEG:0]     seg_sum;

    if (g == 0) begin : g_src
      // Subtraction is A + ~B + !cin
      assign src_v = bus.in_valid;
      assign src_a = bus.a;
      assign src_b = bus.b ^ {WIDTH{bus.sub}};
      assign src_c = bus.cin ^ bus.sub;
      assign src_s = '0;
    end else begin : g_src
      assign src_v = g_stage[g-1].vld_q;
      assign src_a = g_stage[g-1].g_fwd.a_q;
      assign src_b = g_stage[g-1].g_fwd.b_q;
      assign src_c = g_stage[g-1].g_fwd.c_q;
      assign src_s = g_stage[g-1].s_q;
    end

    assign seg_sum = {1'b0, src_a[g*SEG +: SEG]} + {1'b0, src_b[g*SEG +: SEG]}
                   + {{SEG{1'b0}}, src_c};

    // Merge this stage's segment into the partial result carried forward
    always_comb begin
      s_d                = src_s;
      s_d[g*SEG +: SEG]  = seg_sum[SEG-1:0];
    end

    // Token valid bit and partial sum shift together on advance
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        s_q   <= '0;
      end else if (adv) begin
        vld_q <= src_v;
        s_q   <= s_d;
      end
    end

    if (g < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             c_q;

      // Operands and the segment carry travel with the token
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          a_q <= src_a;
          b_q <= src_b;
          c_q <= seg_sum[SEG];
        end
      end
    end else begin : g_last
      logic cout_q;
      logic ovf_q;
      logic zero_q;

      // Flags from the completed sum; carry into MSB recovered as a^b^s at MSB
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          cout_q <= seg_sum[SEG];
          ovf_q  <= src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ s_d[WIDTH-1] ^ seg_sum[SEG];
          zero_q <= (s_d == '0);
        end
      end

      assign out_vld       = vld_q;
      assign bus.out_valid = vld_q;
      assign bus.sum       = s_q;
      assign bus.cout      = cout_q;
      assign bus.ovf       = ovf_q;
      assign bus.zero      = zero_q;
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed boundaries, streaming,
// back-pressure, mid-stream reset and a parameter sweep against an
// arithmetic reference model.
module tb_addsub_pipe;
  typedef struct {
    int sum;
    bit cout;
    bit ovf;
    bit zero;
    int cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  bit   lat_en = 1'b1;
  exp_t q [4][$];
  bit   hv [4];
  exp_t snap [4];

  // Instance index: 0 = 8/4 main, 1 = 16/4, 2 = 8/8, 3 = 12/3
  localparam int STG [4] = '{2, 4, 1, 4};

  int ta [6] = '{'hFF, 'h7F, 'h05, 'h00, 'h80, 'h10};
  int tb [6] = '{'h01, 'h01, 'h03, 'h01, 'h01, 'h10};
  int tc [6] = '{0, 0, 1, 0, 0, 1};
  int ts [6] = '{0, 0, 0, 1, 1, 1};
  int es [6] = '{'h00, 'h80, 'h09, 'hFF, 'h7F, 'hFF};
  int ec [6] = '{1, 0, 0, 0, 1, 0};
  int eo [6] = '{0, 1, 0, 0, 1, 0};
  int ez [6] = '{1, 0, 0, 0, 0, 0};

  addsub_pipe_if #(.WIDTH(8))  bus8  ();
  addsub_pipe_if #(.WIDTH(16)) bus16 ();
  addsub_pipe_if #(.WIDTH(8))  bus8s ();
  addsub_pipe_if #(.WIDTH(12)) bus12 ();

  addsub_pipe #(.WIDTH(8),  .SEG(4)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  addsub_pipe #(.WIDTH(16), .SEG(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
  addsub_pipe #(.WIDTH(8),  .SEG(8)) u_dut8s (.clk(clk), .rst_n(rst_n), .bus(bus8s.slave));
  addsub_pipe #(.WIDTH(12), .SEG(3)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12.slave));

  // Reference: plain integer arithmetic on the full-width values
  function automatic exp_t model(int w, int a, int b, bit cin, bit sub);
    exp_t e;
    int m, r, sa, sb, sr;
    m      = 1 << w;
    r      = sub ? (a - b - int'(cin)) : (a + b + int'(cin));
    e.sum  = ((r % m) + m) % m;
    e.cout = sub ? (r >= 0) : (r >= m);
    sa     = (a >= m / 2) ? a - m : a;
    sb     = (b >= m / 2) ? b - m : b;
    sr     = sub ? (sa - sb - int'(cin)) : (sa + sb + int'(cin));
    e.ovf  = (sr < -(m / 2)) || (sr >= m / 2);
    e.zero = (e.sum == 0);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output side of one cycle: compare consumed results, verify hold stability
  task automatic obs(int i, logic ov, logic ordy, logic [31:0] s, logic c, logic o, logic z);
    exp_t e;
    if (ov === 1'b1 && ordy === 1'b1) begin
      hv[i] = 1'b0;
      checks++;
      assert (q[i].size() != 0) else begin
        errors++;
        $error("FAIL dut%0d unexpected_result: observed sum=%0h expected no result", i, s);
      end
      if (q[i].size() != 0) begin
        e = q[i].pop_front();
        chk($sformatf("dut%0d sum", i), s, e.sum);
        chk($sformatf("dut%0d cout", i), {31'b0, c}, {31'b0, e.cout});
        chk($sformatf("dut%0d ovf", i), {31'b0, o}, {31'b0, e.ovf});
        chk($sformatf("dut%0d zero", i), {31'b0, z}, {31'b0, e.zero});
        if (lat_en) chk($sformatf("dut%0d latency", i), cyc - e.cyc, STG[i]);
      end
    end else if (ov === 1'b1) begin
      if (hv[i]) begin
        chk($sformatf("dut%0d hold_sum", i), s, snap[i].sum);
        chk($sformatf("dut%0d hold_flags", i), {29'b0, c, o, z},
            {29'b0, snap[i].cout, snap[i].ovf, snap[i].zero});
      end
      hv[i]        = 1'b1;
      snap[i].sum  = s;
      snap[i].cout = c;
      snap[i].ovf  = o;
      snap[i].zero = z;
    end else begin
      hv[i] = 1'b0;
    end
  endtask

  // Input side of one cycle: record a token the pipe takes at the next edge
  task automatic acc(int i, logic iv, logic ir, exp_t e);
    exp_t t;
    t = e;
    if (iv === 1'b1 && ir === 1'b1) begin
      t.cyc = cyc;
      q[i].push_back(t);
    end
  endtask

  // One cycle on the main DUT, entered and left at a falling edge
  task automatic step(bit v, bit rdy, int a, int b, bit cin, bit sub, exp_t e);
    bus8.in_valid  = v;
    bus8.a         = a[7:0];
    bus8.b         = b[7:0];
    bus8.cin       = cin;
    bus8.sub       = sub;
    bus8.out_ready = rdy;
    #1;
    obs(0, bus8.out_valid, bus8.out_ready, bus8.sum, bus8.cout, bus8.ovf, bus8.zero);
    acc(0, bus8.in_valid, bus8.in_ready, e);
    @(negedge clk);
  endtask

  task automatic rstep(bit v, bit rdy);
    int a, b;
    bit c, s;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    c = 1'($urandom_range(0, 1));
    s = 1'($urandom_range(0, 1));
    step(v, rdy, a, b, c, s, model(8, a, b, c, s));
  endtask

  initial begin
    exp_t e;
    bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b1; bus8.a  = '0; bus8.b  = '0;
    bus8.cin       = 1'b0; bus8.sub        = 1'b0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.a = '0; bus16.b = '0;
    bus16.cin      = 1'b0; bus16.sub       = 1'b0;
    bus8s.in_valid = 1'b0; bus8s.out_ready = 1'b1; bus8s.a = '0; bus8s.b = '0;
    bus8s.cin      = 1'b0; bus8s.sub       = 1'b0;
    bus12.in_valid = 1'b0; bus12.out_ready = 1'b1; bus12.a = '0; bus12.b = '0;
    bus12.cin      = 1'b0; bus12.sub       = 1'b0;

    // Reset state
    #8;
    chk("reset out_valid", {31'b0, bus8.out_valid}, 32'd0);
    chk("reset sum", {24'b0, bus8.sum}, 32'd0);
    chk("reset flags", {29'b0, bus8.cout, bus8.ovf, bus8.zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready after reset", {31'b0, bus8.in_ready}, 32'd1);
    @(negedge clk);

    // Directed add/subtract boundaries with literal expectations
    for (int k = 0; k < 6; k++) begin
      e.sum  = es[k];
      e.cout = ec[k][0];
      e.ovf  = eo[k][0];
      e.zero = ez[k][0];
      e.cyc  = 0;
      step(1'b1, 1'b1, ta[k], tb[k], tc[k][0], ts[k][0], e);
    end
    for (int k = 0; k < 4; k++) rstep(1'b0, 1'b1);
    chk("directed drained", q[0].size(), 0);

    // Back-to-back stream: exact latency per token implies no gaps
    for (int k = 0; k < 16; k++) rstep(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) rstep(1'b0, 1'b1);
    chk("stream drained", q[0].size(), 0);

    // Back-pressure with a full pipe
    lat_en = 1'b0;
    rstep(1'b1, 1'b1);
    rstep(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      rstep(1'b1, 1'b0);
      chk("backpressure in_ready", {31'b0, bus8.in_ready}, 32'd0);
      chk("backpressure out_valid", {31'b0, bus8.out_valid}, 32'd1);
    end
    for (int k = 0; k < 6; k++) rstep(1'b1, 1'b1);
    // Random bubbles and stalls
    for (int k = 0; k < 80; k++)
      rstep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    for (int k = 0; k < 6; k++) rstep(1'b0, 1'b1);
    chk("backpressure drained", q[0].size(), 0);
    lat_en = 1'b1;

    // Reset with two tokens in flight
    rstep(1'b1, 1'b1);
    rstep(1'b1, 1'b1);
    chk("pre-reset out_valid", {31'b0, bus8.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", {31'b0, bus8.out_valid}, 32'd0);
    chk("async reset flags", {29'b0, bus8.cout, bus8.ovf, bus8.zero}, 32'd0);
    q[0].delete();
    hv[0] = 1'b0;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rstep(1'b0, 1'b1);
      chk("no stale result", {31'b0, bus8.out_valid}, 32'd0);
    end

    // Parameter sweep: 1000 back-to-back random sets per variant
    for (int n = 0; n < 1010; n++) begin
      int ra, rb;
      bit v, rc, rs;
      v  = (n < 1000);
      ra = int'($urandom_range(0, 65535));
      rb = int'($urandom_range(0, 65535));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      bus16.in_valid = v; bus16.a = ra[15:0]; bus16.b = rb[15:0]; bus16.cin = rc; bus16.sub = rs;
      bus8s.in_valid = v; bus8s.a = ra[7:0];  bus8s.b = rb[7:0];  bus8s.cin = rc; bus8s.sub = rs;
      bus12.in_valid = v; bus12.a = ra[11:0]; bus12.b = rb[11:0]; bus12.cin = rc; bus12.sub = rs;
      #1;
      obs(1, bus16.out_valid, bus16.out_ready, bus16.sum, bus16.cout, bus16.ovf, bus16.zero);
      obs(2, bus8s.out_valid, bus8s.out_ready, bus8s.sum, bus8s.cout, bus8s.ovf, bus8s.zero);
      obs(3, bus12.out_valid, bus12.out_ready, bus12.sum, bus12.cout, bus12.ovf, bus12.zero);
      acc(1, bus16.in_valid, bus16.in_ready, model(16, ra & 'hFFFF, rb & 'hFFFF, rc, rs));
      acc(2, bus8s.in_valid, bus8s.in_ready, model(8, ra & 'hFF, rb & 'hFF, rc, rs));
      acc(3, bus12.in_valid, bus12.in_ready, model(12, ra & 'hFFF, rb & 'hFFF, rc, rs));
      @(negedge clk);
    end
    chk("sweep16 drained", q[1].size(), 0);
    chk("sweep8x8 drained", q[2].size(), 0);
    chk("sweep12 drained", q[3].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
